// File: rtl/rd_sched_pkg.sv
// Shared types and helpers for the round-robin request scheduler.
// Holds the FSM encoding, a constant clog2, and the round-robin pick function.
package rd_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   localparam int MAX_REQ = 16;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // First set bit searching last+1, last+2, ... modulo n.
   function automatic int rr_pick(input logic [MAX_REQ-1:0] pend, input int last, input int n);
      int  idx;
      int  res;
      bit  found;
      res   = 0;
      found = 1'b0;
      for (int k = 1; k <= MAX_REQ; k++) begin
         if (k <= n && !found) begin
            idx = (last + k) % n;
            if (pend[idx[3:0]]) begin
               res   = idx;
               found = 1'b1;
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rd_req_sched_if.sv
// Request/grant/status bundle between requesters, resource and the scheduler.
// The scheduler is the slave side; the requester/resource environment is the master.
interface rd_req_sched_if #(
   parameter int N_REQ = 4
);
   localparam int ID_W = rd_sched_pkg::clog2(N_REQ);

   logic [N_REQ-1:0] async_req;
   logic             enable;
   logic             res_done;
   logic             clr_err;
   logic             grant_valid;
   logic [ID_W-1:0]  grant_id;
   logic [N_REQ-1:0] grant_onehot;
   logic             res_busy;
   logic [N_REQ-1:0] pending;
   logic [N_REQ-1:0] overrun;
   logic             timeout_err;

   modport master (
      output async_req, enable, res_done, clr_err,
      input  grant_valid, grant_id, grant_onehot, res_busy, pending, overrun, timeout_err
   );

   modport slave (
      input  async_req, enable, res_done, clr_err,
      output grant_valid, grant_id, grant_onehot, res_busy, pending, overrun, timeout_err
   );
endinterface

// File: rtl/rd_req_sync_edge.sv
// Multi-flop synchronizer plus rising-edge detector for one foreign-domain request line.
// rise_o is a one-cycle pulse SYNC_STAGES cycles after the level is first sampled high.
module rd_req_sync_edge #(
   parameter int SYNC_STAGES = 3
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic rise_o
);
   (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   prev_q;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], async_i};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/rd_req_sched.sv
// Round-robin scheduler granting one slow resource to N_REQ asynchronous requesters.
// Grant-to-grant is at least 3 cycles; a grant holds until res_done or the WAIT timeout.
module rd_req_sched
   import rd_sched_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int SYNC_STAGES = 3,
   parameter int TIMEOUT     = 255
) (
   input  logic           clk_i,
   input  logic           rst_i,
   rd_req_sched_if.slave  bus
);
   localparam int ID_W  = clog2(N_REQ);
   localparam int CNT_W = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [N_REQ-1:0] pending_q, pending_d;
   logic [N_REQ-1:0] overrun_q, overrun_d;
   logic             timeout_err_q, timeout_err_d;
   logic [ID_W-1:0]  last_q, last_d;
   logic [ID_W-1:0]  grant_id_q, grant_id_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N_REQ-1:0] rise;
   logic [N_REQ-1:0] gnt_clr;
   logic [ID_W-1:0]  pick;
   logic             to_hit;
   logic             busy;

   for (genvar g = 0; g < N_REQ; g++) begin : g_sync
      rd_req_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .async_i (bus.async_req[g]),
         .rise_o  (rise[g])
      );
   end

   assign pick = ID_W'(rr_pick(MAX_REQ'(pending_q), int'(last_q), N_REQ));

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      grant_id_d = grant_id_q;
      cnt_d      = cnt_q;
      gnt_clr    = '0;
      to_hit     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.enable && (|pending_q)) begin
               gnt_clr    = N_REQ'(1) << pick;
               grant_id_d = pick;
               last_d     = pick;
               state_d    = ST_GRANT;
            end
         end
         ST_GRANT: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            // Completion takes priority over a coincident timeout.
            if (bus.res_done) begin
               state_d = ST_IDLE;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               to_hit  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A rise on the bit being granted re-arms it without counting as an overrun.
   assign pending_d     = (pending_q & ~gnt_clr) | rise;
   assign overrun_d     = (bus.clr_err ? '0 : overrun_q) | (rise & pending_q & ~gnt_clr);
   assign timeout_err_d = (timeout_err_q & ~bus.clr_err) | to_hit;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= ST_IDLE;
         pending_q     <= '0;
         overrun_q     <= '0;
         timeout_err_q <= 1'b0;
         last_q        <= ID_W'(N_REQ - 1);
         grant_id_q    <= '0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         overrun_q     <= overrun_d;
         timeout_err_q <= timeout_err_d;
         last_q        <= last_d;
         grant_id_q    <= grant_id_d;
         cnt_q         <= cnt_d;
      end
   end

   assign busy             = (state_q != ST_IDLE);
   assign bus.res_busy     = busy;
   assign bus.grant_valid  = (state_q == ST_GRANT);
   assign bus.grant_id     = grant_id_q;
   assign bus.grant_onehot = busy ? (N_REQ'(1) << grant_id_q) : '0;
   assign bus.pending      = pending_q;
   assign bus.overrun      = overrun_q;
   assign bus.timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_rd_req_sched.sv
// Bench for rd_req_sched: directed scenarios plus random traffic against a cycle model.
module tb_rd_req_sched;
   localparam int N  = 4;
   localparam int S  = 3;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   rd_req_sched_if #(.N_REQ(N)) bus();

   rd_req_sched #(.N_REQ(N), .SYNC_STAGES(S), .TIMEOUT(TO)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int glog[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic int gl(input int i);
      return (i < glog.size()) ? glog[i] : -1;
   endfunction

   // Reference model: phase 0 idle, 1 grant cycle, 2 waiting for the resource.
   bit [N-1:0] m_pend, m_ovr, m_rise, m_gclr;
   bit [N-1:0] m_samp [0:S];
   bit         m_terr;
   int         m_phase, m_wcnt, m_last, m_gid, m_idx;
   bit         m_found;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pend = '0; m_ovr = '0; m_terr = 1'b0;
         m_phase = 0; m_wcnt = 0; m_last = N - 1; m_gid = 0;
         for (int k = 0; k <= S; k++) m_samp[k] = '0;
      end else begin
         // A request counts when the level seen S edges ago was high and the one before low.
         m_rise = m_samp[S-1] & ~m_samp[S];
         for (int k = S; k > 0; k--) m_samp[k] = m_samp[k-1];
         m_samp[0] = bus.async_req;
         m_gclr = '0;
         if (bus.clr_err) begin
            m_ovr  = '0;
            m_terr = 1'b0;
         end
         if (m_phase == 0) begin
            if (bus.enable && m_pend != 0) begin
               m_found = 1'b0;
               for (int k = 1; k <= N; k++) begin
                  m_idx = (m_last + k) % N;
                  if (!m_found && m_pend[m_idx]) begin
                     m_found = 1'b1;
                     m_gid = m_idx;
                  end
               end
               m_gclr[m_gid] = 1'b1;
               m_last  = m_gid;
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            m_phase = 2;
            m_wcnt  = 0;
         end else begin
            if (bus.res_done) m_phase = 0;
            else if (m_wcnt == TO - 1) begin
               m_terr  = 1'b1;
               m_phase = 0;
            end else m_wcnt++;
         end
         for (int i = 0; i < N; i++) begin
            if (m_rise[i]) begin
               if (m_pend[i] && !m_gclr[i]) m_ovr[i] = 1'b1;
               m_pend[i] = 1'b1;
            end else if (m_gclr[i]) m_pend[i] = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("pending",      int'(bus.pending),      int'(m_pend));
         chk("overrun",      int'(bus.overrun),      int'(m_ovr));
         chk("timeout_err",  int'(bus.timeout_err),  int'(m_terr));
         chk("grant_valid",  int'(bus.grant_valid),  (m_phase == 1) ? 1 : 0);
         chk("res_busy",     int'(bus.res_busy),     (m_phase != 0) ? 1 : 0);
         chk("grant_id",     int'(bus.grant_id),     m_gid);
         chk("grant_onehot", int'(bus.grant_onehot), (m_phase != 0) ? (1 << m_gid) : 0);
         if (bus.grant_valid) glog.push_back(int'(bus.grant_id));
      end
   end

   // Resource responder: done pulse done_lat cycles after a grant, or random noise.
   int done_lat  = 2;
   int rcnt      = 1000;
   bit rand_done = 1'b0;

   always @(negedge clk) begin
      if (bus.grant_valid) rcnt = 0;
      else if (rcnt < 1000) rcnt++;
      if (rand_done) bus.res_done = ($urandom_range(0, 3) == 0);
      else           bus.res_done = (done_lat > 0) && (rcnt == done_lat);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle(input int budget);
      int c = 0;
      while ((bus.res_busy || bus.pending != 0) && c < budget) begin
         tick(1);
         c++;
      end
      if (c >= budget) begin
         checks++; errors++;
         $display("FAIL wait_idle actual=busy required=idle within %0d cycles", budget);
      end
   endtask

   task automatic wait_grant(input int budget);
      int c = 0;
      while (!bus.grant_valid && c < budget) begin
         tick(1);
         c++;
      end
      if (c >= budget) begin
         checks++; errors++;
         $display("FAIL wait_grant actual=none required=grant within %0d cycles", budget);
      end
   endtask

   task automatic count_wait(output int w);
      w = 0;
      tick(1);
      while (bus.res_busy && w < 50) begin
         w++;
         tick(1);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
   endtask

   int hold [N];
   int w;

   initial begin
      bus.async_req = '0;
      bus.enable    = 1'b1;
      bus.clr_err   = 1'b0;
      tick(3);
      rst = 1'b0;
      chk("rst_pending",  int'(bus.pending),  0);
      chk("rst_busy",     int'(bus.res_busy), 0);
      chk("rst_grant_id", int'(bus.grant_id), 0);

      // Synchronizer latency and first grant.
      bus.async_req = 4'b0100;
      tick(3);
      chk("lat_pend_edge3", int'(bus.pending), 0);
      tick(1);
      chk("lat_pend_edge4", int'(bus.pending), 4);
      tick(1);
      chk("first_gv",      int'(bus.grant_valid),  1);
      chk("first_gid",     int'(bus.grant_id),     2);
      chk("first_onehot",  int'(bus.grant_onehot), 4);
      chk("first_pending", int'(bus.pending),      0);
      wait_idle(50);

      // Round-robin order from reset, then wrap after last=3.
      bus.async_req = '0;
      tick(S + 2);
      do_reset();
      glog.delete();
      bus.async_req = 4'b1011;
      tick(S + 2);
      wait_idle(100);
      chk("rr1_count", glog.size(), 3);
      chk("rr1_g0", gl(0), 0);
      chk("rr1_g1", gl(1), 1);
      chk("rr1_g2", gl(2), 3);
      bus.async_req = '0;
      tick(S + 2);
      glog.delete();
      bus.async_req = 4'b1111;
      tick(S + 2);
      wait_idle(100);
      chk("rr2_count", glog.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("rr2_g%0d", i), gl(i), i);

      // Timeout with no completion, clear, then completion on the last WAIT cycle.
      bus.async_req = '0;
      tick(S + 2);
      done_lat = 0;
      bus.async_req = 4'b0010;
      wait_grant(50);
      count_wait(w);
      chk("to_wait_cycles", w, 8);
      chk("to_err_set", int'(bus.timeout_err), 1);
      bus.clr_err = 1'b1;
      tick(1);
      bus.clr_err = 1'b0;
      chk("to_err_cleared", int'(bus.timeout_err), 0);
      bus.async_req = '0;
      tick(S + 2);
      done_lat = 8;
      bus.async_req = 4'b0010;
      wait_grant(50);
      count_wait(w);
      chk("done_last_wait_cycles", w, 8);
      chk("done_last_no_err", int'(bus.timeout_err), 0);

      // Overrun: two edges while grants are disabled yield one grant.
      bus.async_req = '0;
      done_lat = 2;
      tick(S + 2);
      wait_idle(50);
      bus.enable = 1'b0;
      bus.async_req = 4'b0010;
      tick(4);
      bus.async_req = '0;
      tick(4);
      bus.async_req = 4'b0010;
      tick(S + 2);
      chk("ovr_flag",    int'(bus.overrun),  2);
      chk("ovr_pending", int'(bus.pending),  2);
      chk("ovr_idle",    int'(bus.res_busy), 0);
      glog.delete();
      bus.enable = 1'b1;
      tick(2);
      wait_idle(50);
      chk("ovr_grants", glog.size(), 1);
      chk("ovr_gid",    gl(0), 1);
      bus.clr_err = 1'b1;
      tick(1);
      bus.clr_err = 1'b0;
      chk("ovr_cleared", int'(bus.overrun), 0);

      // Re-request landing on the same edge as its own grant.
      bus.async_req = '0;
      tick(S + 2);
      bus.enable = 1'b0;
      bus.async_req = 4'b0001;
      tick(S + 2);
      bus.async_req = '0;
      tick(3);
      glog.delete();
      bus.async_req = 4'b0001;
      tick(3);
      bus.enable = 1'b1;
      tick(1);
      chk("coin_gv",      int'(bus.grant_valid), 1);
      chk("coin_gid",     int'(bus.grant_id),    0);
      chk("coin_pending", int'(bus.pending),     1);
      chk("coin_overrun", int'(bus.overrun),     0);
      wait_idle(100);
      chk("coin_grants", glog.size(), 2);
      chk("coin_g1",     gl(1), 0);

      // Asynchronous reset while the resource is busy.
      bus.async_req = '0;
      tick(S + 2);
      done_lat = 0;
      bus.async_req = 4'b1110;
      tick(S + 2);
      wait_grant(50);
      tick(2);
      chk("arst_pre_busy", int'(bus.res_busy), 1);
      rst = 1'b1;
      #1;
      chk("arst_busy",    int'(bus.res_busy), 0);
      chk("arst_pending", int'(bus.pending),  0);
      chk("arst_gid",     int'(bus.grant_id), 0);
      tick(2);
      rst = 1'b0;
      glog.delete();
      done_lat = 2;
      tick(S + 2);
      wait_idle(100);
      chk("arst_grants", glog.size(), 3);
      chk("arst_first",  gl(0), 1);

      // Random traffic; every level is held at least 3 cycles.
      rand_done = 1'b1;
      for (int i = 0; i < N; i++) hold[i] = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (hold[i] == 0) begin
               bus.async_req[i] = 1'($urandom_range(0, 1));
               hold[i] = $urandom_range(2, 6);
            end else hold[i]--;
         end
         bus.enable  = ($urandom_range(0, 7) != 0);
         bus.clr_err = ($urandom_range(0, 15) == 0);
      end
      rand_done     = 1'b0;
      bus.async_req = '0;
      bus.clr_err   = 1'b0;
      tick(10);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end
endmodule

// File: doc/rd_req_sched.md
Name: rd_req_sched

Overview:
- Single-clock round-robin scheduler that shares one slow resource, such as a readout/config engine, between N_REQ requesters in unrelated clock domains.
- Each asynchronous request line is synchronized internally, then rising-edge detected and latched as pending.
- Pending requests are granted one at a time; each grant is held until the resource signals completion or a timeout expires.

Parameters:
N_REQ, 4, number of requesters (2..16)
SYNC_STAGES, 3, synchronizer flops per request line (>=3)
TIMEOUT, 255, max cycles in WAIT before abort; 0 disables timeout
ID_W, clog2(N_REQ), grant index width (derived, not overridable)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
ASYNC_REQ  in  N_REQ  request levels from foreign domains; a rising edge means one request
ENABLE  in  1  1 = new grants allowed
RES_DONE  in  1  resource completion pulse, sampled in WAIT only
CLR_ERR  in  1  synchronous clear of sticky error flags
GRANT_VALID  out  1  one-cycle pulse per grant
GRANT_ID  out  ID_W  index of current/last grant, stable from grant to next grant
GRANT_ONEHOT  out  N_REQ  one-hot of GRANT_ID while RES_BUSY=1, else 0
RES_BUSY  out  1  high in GRANT and WAIT
PENDING  out  N_REQ  latched, not-yet-granted requests
OVERRUN  out  N_REQ  sticky: edge arrived while that bit was already pending
TIMEOUT_ERR  out  1  sticky: a WAIT was aborted by timeout

Behaviour:
- Reset, async and immediate: all outputs 0, all sync/edge flops 0, state IDLE, timeout counter 0, round-robin pointer last=N_REQ-1 so request 0 has first priority.
- Sync and edge detect, per bit:
  - Chain s[0..S-1] with S=SYNC_STAGES, plus prev flop; rise = s[S-1] & ~prev.
  - ASYNC_REQ first sampled high at edge 1 -> PENDING bit set at edge S+1 (S+1 cycles of latency).
  - Levels must stay stable >= 2 CLK periods; narrower pulses may be lost (no requirement).
- Pending update, per bit, each edge:
  - If rise: set. Also set OVERRUN if the bit was already set and is not being cleared this cycle.
  - Else if granted this edge: clear.
  - A rise coincident with the grant of the same bit re-sets pending; this is not an overrun.
- FSM:
  - IDLE: if ENABLE and PENDING!=0, pick the first set bit searching last+1, last+2, ... mod N_REQ. At that edge: GRANT_ID<=pick, clear pending[pick], last<=pick, go to GRANT.
  - GRANT, 1 cycle: GRANT_VALID=1, RES_BUSY=1. Timeout counter cleared. Go to WAIT.
  - WAIT: RES_BUSY=1, counter increments each cycle.
    - RES_DONE=1 -> IDLE.
    - Else if TIMEOUT!=0 and counter==TIMEOUT-1 -> set TIMEOUT_ERR, go to IDLE.
    - RES_DONE and timeout in the same cycle: DONE wins, no error.
- Throughput: minimum grant-to-grant is 3 cycles (GRANT, WAIT with DONE, IDLE).
- RES_DONE outside WAIT is ignored.
- ENABLE=0 mid-transaction: the current grant completes normally; no new grant until ENABLE=1. Pending bits keep accumulating.
- CLR_ERR clears OVERRUN and TIMEOUT_ERR next edge. A set event in the same cycle wins.
- Counter width clog2(TIMEOUT+1); no wrap is possible because the FSM exits at TIMEOUT-1.

Decomposition:
- Package rd_sched_pkg holds:
  - state encoding (IDLE=2'd0, GRANT=2'd1, WAIT=2'd2)
  - clog2 function
  - round-robin pick function: (pending, last) -> index
- Sub-module rd_req_sync_edge, instantiated N_REQ times:
  - ports CLK, RST, ASYNC_IN, RISE_OUT
  - ASYNC_REG and SHREG_EXTRACT="NO" on the chain
  - async reset to 0

Test Plan:
- Reset/latency: hold RST 3 cycles, raise ASYNC_REQ[2] -> PENDING[2]=1 exactly 4 edges after first sampling edge (S=3). Next cycle GRANT_VALID=1, GRANT_ID=2, GRANT_ONEHOT=4'b0100, PENDING=0.
- Round-robin: raise REQ[0], [1], [3] together, DONE 2 cycles after each grant -> grant order 0, 1, 3. Raise all again -> order 0, 1, 2, 3 (last=3 wraps to 0).
- Timeout: TIMEOUT=8, never assert DONE -> RES_BUSY drops after 8 WAIT cycles, TIMEOUT_ERR=1. CLR_ERR pulse -> TIMEOUT_ERR=0. DONE on cycle 8 (counter=7) -> no error.
- Overrun: two edges on REQ[1] while ENABLE=0 -> OVERRUN[1]=1, PENDING[1]=1, exactly one grant after ENABLE=1.
- Coincident re-request: time REQ[0] edge so rise lands on its grant edge -> PENDING[0] stays 1, OVERRUN[0]=0, second grant to 0 follows.
- Async reset mid-WAIT: assert RST while RES_BUSY=1 -> RES_BUSY, PENDING, GRANT_ID go to 0 without a clock edge. After release, state is IDLE and the first grant goes to the lowest pending index.
